// File: rtl/pixel_stream_reader.sv
// pixel_stream_reader
//
// Read side of the drawing-canvas flip-flop array. When a start request
// arrives it takes a snapshot of the WIDTH x HEIGHT binary canvas. It then
// streams that snapshot one pixel per transfer, in raster order, over a
// valid/ready handshake. The snapshot keeps the recognition datapath
// isolated from canvas edits that the drawing logic makes mid-stream.
//
// Ports
//   Clock      single clock, rising edge
//   Clr_n      synchronous active-low reset
//   Frame      canvas bits, bit r*WIDTH+c is pixel (r,c)
//   Start      start request, honoured only while idle
//   Abort      cancel the stream in progress (no Done pulse)
//   Pix_Ready  consumer accepts the current pixel
//   Pix_Valid  pixel outputs are valid
//   Pix_Data   pixel value
//   Pix_Row    row of the current pixel
//   Pix_Col    column of the current pixel
//   Pix_Last   current pixel is the final one of the frame
//   Busy       block is not idle
//   Done       one-cycle pulse after the last transfer
//
// All outputs come straight from flops.

module pixel_stream_reader #(
  parameter int WIDTH  = 28,
  parameter int HEIGHT = 28,
  localparam int ROW_W = $clog2(HEIGHT),
  localparam int COL_W = $clog2(WIDTH)
) (
  input  logic                      Clock,
  input  logic                      Clr_n,
  input  logic [WIDTH*HEIGHT-1:0]   Frame,
  input  logic                      Start,
  input  logic                      Abort,
  input  logic                      Pix_Ready,
  output logic                      Pix_Valid,
  output logic                      Pix_Data,
  output logic [ROW_W-1:0]          Pix_Row,
  output logic [COL_W-1:0]          Pix_Col,
  output logic                      Pix_Last,
  output logic                      Busy,
  output logic                      Done
);

  localparam int NUM_PIX = WIDTH * HEIGHT;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [COL_W-1:0] COL_MAX    = COL_W'(WIDTH - 1);
  localparam logic [COL_W-1:0] COL_PENULT = COL_W'(WIDTH - 2);
  localparam logic [ROW_W-1:0] ROW_MAX    = ROW_W'(HEIGHT - 1);

  logic [1:0]         state;
  // Pixels not yet presented. Bit 0 is always the next pixel in raster
  // order, so advancing is a plain shift. Pix_Data holds the pixel that is
  // currently on the bus. Pixel (0,0) goes straight into Pix_Data at start.
  logic [NUM_PIX-2:0] pending;
  logic               transfer;

  assign transfer = Pix_Valid & Pix_Ready;

  // Controller and output registers. Pix_Last is precomputed one transfer
  // ahead, so it can be registered like the other outputs. It rises when
  // the pixel before the final one is accepted.
  always_ff @(posedge Clock) begin
    if (!Clr_n) begin
      state     <= S_IDLE;
      pending   <= '0;
      Pix_Valid <= 1'b0;
      Pix_Data  <= 1'b0;
      Pix_Row   <= '0;
      Pix_Col   <= '0;
      Pix_Last  <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            state     <= S_STREAM;
            pending   <= Frame[NUM_PIX-1:1];
            Pix_Data  <= Frame[0];
            Pix_Row   <= '0;
            Pix_Col   <= '0;
            Pix_Last  <= 1'b0;
            Pix_Valid <= 1'b1;
            Busy      <= 1'b1;
          end
        end

        S_STREAM: begin
          if (Abort) begin
            state     <= S_IDLE;
            Pix_Valid <= 1'b0;
            Pix_Data  <= 1'b0;
            Pix_Row   <= '0;
            Pix_Col   <= '0;
            Pix_Last  <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
          end else if (transfer) begin
            if (Pix_Last) begin
              state     <= S_DONE;
              Pix_Valid <= 1'b0;
              Pix_Data  <= 1'b0;
              Pix_Row   <= '0;
              Pix_Col   <= '0;
              Pix_Last  <= 1'b0;
              Done      <= 1'b1;
            end else begin
              Pix_Data <= pending[0];
              pending  <= pending >> 1;
              if (Pix_Col == COL_MAX) begin
                Pix_Col <= '0;
                Pix_Row <= Pix_Row + 1'b1;
              end else begin
                Pix_Col <= Pix_Col + 1'b1;
              end
              Pix_Last <= (Pix_Row == ROW_MAX) && (Pix_Col == COL_PENULT);
            end
          end
        end

        S_DONE: begin
          // Abort here lands in the same place, so it needs no separate path.
          state <= S_IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end

        default: begin
          state     <= S_IDLE;
          Pix_Valid <= 1'b0;
          Pix_Data  <= 1'b0;
          Pix_Row   <= '0;
          Pix_Col   <= '0;
          Pix_Last  <= 1'b0;
          Busy      <= 1'b0;
          Done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_stream_reader.sv
// tb_pixel_stream_reader
//
// Bench for pixel_stream_reader. It has two instances: a default 28x28
// reader and a small 4x2 reader. Issuing a start request pushes the whole
// expected raster sequence into a per-instance queue. A monitor on each
// instance pops one entry per accepted transfer and checks pixel value,
// position and Last. It also tracks the expected Done pulse and the
// state after abort and reset.

module tb_pixel_stream_reader;

  localparam int BW = 28;
  localparam int BH = 28;
  localparam int BP = BW * BH;
  localparam int SW = 4;
  localparam int SH = 2;
  localparam int SP = SW * SH;

  typedef struct {
    logic data;
    int   row;
    int   col;
    logic last;
  } pix_t;

  logic clk;
  logic clr_n;

  logic [BP-1:0] b_frame;
  logic          b_start, b_abort, b_ready;
  logic          b_valid, b_data, b_last, b_busy, b_done;
  logic [4:0]    b_row, b_col;

  logic [SP-1:0] s_frame;
  logic          s_start, s_abort, s_ready;
  logic          s_valid, s_data, s_last, s_busy, s_done;
  logic [0:0]    s_row;
  logic [1:0]    s_col;

  pix_t b_q[$];
  pix_t s_q[$];

  int total = 0;
  int bad   = 0;
  int b_xfers = 0;
  int s_xfers = 0;

  bit b_done_due, b_rst_chk, b_abort_chk;
  bit s_done_due, s_rst_chk, s_abort_chk;
  bit s_rand_ready = 0;
  bit b_rand_ready = 0;

  pixel_stream_reader #(.WIDTH(BW), .HEIGHT(BH)) u_big (
    .Clock(clk), .Clr_n(clr_n), .Frame(b_frame), .Start(b_start),
    .Abort(b_abort), .Pix_Ready(b_ready), .Pix_Valid(b_valid),
    .Pix_Data(b_data), .Pix_Row(b_row), .Pix_Col(b_col),
    .Pix_Last(b_last), .Busy(b_busy), .Done(b_done)
  );

  pixel_stream_reader #(.WIDTH(SW), .HEIGHT(SH)) u_small (
    .Clock(clk), .Clr_n(clr_n), .Frame(s_frame), .Start(s_start),
    .Abort(s_abort), .Pix_Ready(s_ready), .Pix_Valid(s_valid),
    .Pix_Data(s_data), .Pix_Row(s_row), .Pix_Col(s_col),
    .Pix_Last(s_last), .Busy(s_busy), .Done(s_done)
  );

  // Free-running clock, first rising edge at 5 ns.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a mismatch (X counts as a mismatch).
  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the raster order is just pixel index p = r*w + c.
  // The value is the frame bit at that index, and only the final index is Last.
  task automatic push_expected(input bit big, input logic [BP-1:0] f,
                               input int w, input int h);
    pix_t e;
    for (int p = 0; p < w * h; p++) begin
      e.data = f[p];
      e.row  = p / w;
      e.col  = p % w;
      e.last = (p == w * h - 1);
      if (big) b_q.push_back(e);
      else     s_q.push_back(e);
    end
  endtask

  // Random per-cycle backpressure. This drives ready only while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (s_rand_ready) s_ready = 1'($urandom_range(0, 1));
      if (b_rand_ready) b_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor for the 28x28 instance.
  always @(negedge clk) begin
    pix_t e;
    if (b_rst_chk || b_abort_chk) begin
      check_output("b_clear_valid", b_valid, 0);
      check_output("b_clear_busy", b_busy, 0);
      check_output("b_clear_row", b_row, 0);
      check_output("b_clear_col", b_col, 0);
      check_output("b_clear_done", b_done, 0);
      if (b_rst_chk) begin
        check_output("b_rst_data", b_data, 0);
        check_output("b_rst_last", b_last, 0);
      end
      b_rst_chk   = 0;
      b_abort_chk = 0;
    end
    if (!clr_n) begin
      b_q.delete();
      b_done_due = 0;
      b_rst_chk  = 1;
    end else begin
      check_output("b_done", b_done, 32'(b_done_due));
      if (b_done_due) check_output("b_done_valid", b_valid, 0);
      b_done_due = 0;
      if (b_valid) begin
        check_output("b_valid_busy", b_busy, 1);
        if (b_q.size() == 0) begin
          check_output("b_unexpected_pixel", b_valid, 0);
        end else begin
          e = b_q[0];
          check_output("b_data", b_data, 32'(e.data));
          check_output("b_row", b_row, e.row);
          check_output("b_col", b_col, e.col);
          check_output("b_last", b_last, 32'(e.last));
          if (b_ready) begin
            void'(b_q.pop_front());
            b_xfers++;
            if (e.last && !b_abort) b_done_due = 1;
          end
        end
      end
      if (b_abort && b_busy) begin
        b_q.delete();
        b_done_due  = 0;
        b_abort_chk = 1;
      end
    end
  end

  // Monitor for the 4x2 instance.
  always @(negedge clk) begin
    pix_t e;
    if (s_rst_chk || s_abort_chk) begin
      check_output("s_clear_valid", s_valid, 0);
      check_output("s_clear_busy", s_busy, 0);
      check_output("s_clear_row", s_row, 0);
      check_output("s_clear_col", s_col, 0);
      check_output("s_clear_done", s_done, 0);
      if (s_rst_chk) begin
        check_output("s_rst_data", s_data, 0);
        check_output("s_rst_last", s_last, 0);
      end
      s_rst_chk   = 0;
      s_abort_chk = 0;
    end
    if (!clr_n) begin
      s_q.delete();
      s_done_due = 0;
      s_rst_chk  = 1;
    end else begin
      check_output("s_done", s_done, 32'(s_done_due));
      if (s_done_due) check_output("s_done_valid", s_valid, 0);
      s_done_due = 0;
      if (s_valid) begin
        check_output("s_valid_busy", s_busy, 1);
        if (s_q.size() == 0) begin
          check_output("s_unexpected_pixel", s_valid, 0);
        end else begin
          e = s_q[0];
          check_output("s_data", s_data, 32'(e.data));
          check_output("s_row", s_row, e.row);
          check_output("s_col", s_col, e.col);
          check_output("s_last", s_last, 32'(e.last));
          if (s_ready) begin
            void'(s_q.pop_front());
            s_xfers++;
            if (e.last && !s_abort) s_done_due = 1;
          end
        end
      end
      if (s_abort && s_busy) begin
        s_q.delete();
        s_done_due  = 0;
        s_abort_chk = 1;
      end
    end
  end

  // Start on the 28x28 instance. Returns 1 ns after the accepting edge.
  task automatic apply_stimulus_big(input logic [BP-1:0] f);
    @(posedge clk);
    #1;
    b_frame = f;
    b_start = 1'b1;
    push_expected(1'b1, f, BW, BH);
    @(posedge clk);
    #1;
    b_start = 1'b0;
  endtask

  task automatic apply_stimulus_small(input logic [SP-1:0] f);
    @(posedge clk);
    #1;
    s_frame = f;
    s_start = 1'b1;
    push_expected(1'b0, BP'(f), SW, SH);
    @(posedge clk);
    #1;
    s_start = 1'b0;
  endtask

  task automatic wait_idle_big(input int limit);
    int k;
    for (k = 0; k < limit; k++) begin
      @(negedge clk);
      if (!b_busy) break;
    end
    check_output("b_idle_timeout", 32'(k < limit), 1);
    check_output("b_queue_drained", b_q.size(), 0);
  endtask

  task automatic wait_idle_small(input int limit);
    int k;
    for (k = 0; k < limit; k++) begin
      @(negedge clk);
      if (!s_busy) break;
    end
    check_output("s_idle_timeout", 32'(k < limit), 1);
    check_output("s_queue_drained", s_q.size(), 0);
  endtask

  function automatic logic [BP-1:0] random_big_frame();
    logic [BP-1:0] f;
    for (int i = 0; i < BP; i++) f[i] = 1'($urandom_range(0, 1));
    return f;
  endfunction

  // Watchdog so the run always ends.
  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [BP-1:0] cb;
    logic [SP-1:0] sf;
    int busy_cnt, done_at;

    // Reset for two cycles while every other input wiggles randomly,
    // including Start, which must be ignored.
    clr_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      b_frame = random_big_frame();
      s_frame = SP'($urandom);
      b_start = 1'($urandom_range(0, 1)) | (i == 0);
      s_start = 1'($urandom_range(0, 1)) | (i == 0);
      b_abort = 1'($urandom_range(0, 1));
      s_abort = 1'($urandom_range(0, 1));
      b_ready = 1'($urandom_range(0, 1));
      s_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    b_start = 0; s_start = 0; b_abort = 0; s_abort = 0;
    b_ready = 0; s_ready = 0;
    clr_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Checkerboard on the default-size reader with continuous ready.
    $display("[TB] checkerboard 28x28");
    for (int r = 0; r < BH; r++)
      for (int c = 0; c < BW; c++)
        cb[r*BW+c] = 1'((r + c) & 1);
    b_ready = 1'b1;
    b_xfers = 0;
    apply_stimulus_big(cb);
    busy_cnt = 0;
    done_at  = 0;
    for (int k = 1; k < 1000; k++) begin
      @(negedge clk);
      if (b_busy) busy_cnt++;
      if (b_done) done_at = k;
      if (!b_busy) break;
    end
    check_output("b_busy_cycles", busy_cnt, BP + 1);
    check_output("b_done_cycle", done_at, BP + 1);
    check_output("b_xfer_count", b_xfers, BP);
    check_output("b_queue_drained", b_q.size(), 0);

    // Fixed 4x2 frame under random backpressure.
    $display("[TB] 4x2 fixed frame, random ready");
    s_xfers = 0;
    s_rand_ready = 1;
    apply_stimulus_small(8'b1011_0010);
    wait_idle_small(200);
    check_output("s_xfer_count", s_xfers, SP);

    // A few random 4x2 frames under random backpressure.
    for (int n = 0; n < 4; n++) begin
      apply_stimulus_small(SP'($urandom));
      wait_idle_small(200);
    end

    // Canvas edits and a second Start while streaming must not leak through.
    $display("[TB] snapshot isolation");
    sf = SP'($urandom);
    apply_stimulus_small(sf);
    s_frame = ~sf;
    @(posedge clk);
    #1;
    s_start = 1'b1;
    @(posedge clk);
    #1;
    s_start = 1'b0;
    wait_idle_small(200);
    repeat (4) @(posedge clk);
    #1;

    // Abort on the same edge as the Last transfer.
    $display("[TB] abort on last transfer");
    s_rand_ready = 0;
    @(posedge clk);
    #1;
    s_ready = 1'b1;
    apply_stimulus_small(8'hA5);
    for (int k = 0; k < 20; k++) begin
      if (s_last) break;
      @(posedge clk);
      #1;
    end
    check_output("s_last_seen", s_last, 1);
    s_abort = 1'b1;
    @(posedge clk);
    #1;
    s_abort = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    apply_stimulus_small(8'h3C);
    wait_idle_small(200);

    // Big random frame under random backpressure.
    $display("[TB] 28x28 random frame, random ready");
    b_rand_ready = 1;
    apply_stimulus_big(random_big_frame());
    wait_idle_big(5000);
    b_rand_ready = 0;

    // Reset after ten transfers, then a clean restart.
    $display("[TB] reset mid-frame");
    @(posedge clk);
    #1;
    b_ready = 1'b1;
    apply_stimulus_big(random_big_frame());
    repeat (10) @(posedge clk);
    #1;
    clr_n = 1'b0;
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    b_xfers = 0;
    apply_stimulus_big(random_big_frame());
    wait_idle_big(2000);
    check_output("b_restart_xfers", b_xfers, BP);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
